// File: rtl/cache_dm_array_pkg.sv
// Shared types and default geometry for the direct-mapped cache array.
package cache_dm_array_pkg;

  localparam int unsigned CACHE_ADDR_W  = 8;
  localparam int unsigned CACHE_INDEX_W = 4;
  localparam int unsigned CACHE_DATA_W  = 19;

  // IDLE services lookups/fills; FLUSH walks every index clearing valid bits.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } cache_state_t;

endpackage : cache_dm_array_pkg

// File: rtl/cache_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address on the same edge returns the old
// contents; the cache top resolves that case with its own bypass.
module cache_sdp_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  // Read port holds its last value when no read is requested.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule : cache_sdp_ram

// File: rtl/cache_dm_array.sv
// Direct-mapped cache array: {tag,data} RAM, valid bits, one-cycle lookup
// with write-first bypass against a same-cycle fill, and a sequential flush.
module cache_dm_array
  import cache_dm_array_pkg::*;
#(
  parameter int unsigned ADDR_W  = CACHE_ADDR_W,
  parameter int unsigned INDEX_W = CACHE_INDEX_W,
  parameter int unsigned DATA_W  = CACHE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              flush_req,
  output logic              busy
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;
  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned ENT_W = TAG_W + DATA_W;

  // Address split
  logic [INDEX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0]   lk_tag_s;
  logic [INDEX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0]   fill_tag_s;

  assign lk_idx_s   = lookup_addr[INDEX_W-1:0];
  assign lk_tag_s   = lookup_addr[ADDR_W-1:INDEX_W];
  assign fill_idx_s = fill_addr[INDEX_W-1:0];
  assign fill_tag_s = fill_addr[ADDR_W-1:INDEX_W];

  // Control state
  cache_state_t       state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               lk_acc_s;
  logic               fill_acc_s;

  // Lookup pipeline stage
  logic               resp_valid_q, resp_valid_d;
  logic               line_valid_q, line_valid_d;
  logic               byp_q, byp_d;
  logic [TAG_W-1:0]   lk_tag_q, lk_tag_d;
  logic [TAG_W-1:0]   byp_tag_q, byp_tag_d;
  logic [DATA_W-1:0]  byp_data_q, byp_data_d;

  // Response resolution
  logic [ENT_W-1:0]   ram_rd_s;
  logic [TAG_W-1:0]   ram_tag_s;
  logic [DATA_W-1:0]  ram_data_s;
  logic               eff_valid_s;
  logic [TAG_W-1:0]   eff_tag_s;
  logic [DATA_W-1:0]  eff_data_s;
  logic               hit_s;

  cache_sdp_ram #(
    .AW (INDEX_W),
    .DW (ENT_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (fill_acc_s),
    .wr_addr (fill_idx_s),
    .wr_data ({fill_tag_s, fill_data}),
    .rd_en   (lk_acc_s),
    .rd_addr (lk_idx_s),
    .rd_data (ram_rd_s)
  );

  assign ram_tag_s  = ram_rd_s[ENT_W-1:DATA_W];
  assign ram_data_s = ram_rd_s[DATA_W-1:0];

  // Next state, flush walk, valid-bit update and request acceptance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    lk_acc_s   = 1'b0;
    fill_acc_s = 1'b0;
    case (state_q)
      IDLE: begin
        lk_acc_s   = lookup_valid;
        fill_acc_s = fill_en;
        if (fill_en) begin
          valid_d[fill_idx_s] = 1'b1;
        end else begin
          valid_d = valid_q;
        end
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = {INDEX_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + INDEX_W'(1);
        if (cnt_q == {INDEX_W{1'b1}}) begin
          state_d = IDLE;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = {INDEX_W{1'b0}};
      end
    endcase
  end

  // Capture everything the response needs, including a same-index fill.
  always_comb begin
    resp_valid_d = lk_acc_s;
    line_valid_d = valid_q[lk_idx_s];
    lk_tag_d     = lk_tag_s;
    byp_d        = fill_acc_s && (fill_idx_s == lk_idx_s);
    byp_tag_d    = fill_tag_s;
    byp_data_d   = fill_data;
  end

  // Write-first resolution and hit compare on the captured lookup.
  always_comb begin
    eff_valid_s = line_valid_q;
    eff_tag_s   = ram_tag_s;
    eff_data_s  = ram_data_s;
    if (byp_q) begin
      eff_valid_s = 1'b1;
      eff_tag_s   = byp_tag_q;
      eff_data_s  = byp_data_q;
    end else begin
      eff_valid_s = line_valid_q;
      eff_tag_s   = ram_tag_s;
      eff_data_s  = ram_data_s;
    end
    hit_s = resp_valid_q && eff_valid_s && (eff_tag_s == lk_tag_q);
  end

  // Control and response-qualifier flops; reset starts a full flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FLUSH;
      cnt_q        <= {INDEX_W{1'b0}};
      resp_valid_q <= 1'b0;
      line_valid_q <= 1'b0;
      byp_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      line_valid_q <= line_valid_d;
      byp_q        <= byp_d;
    end
  end

  // Valid bits and datapath captures; cleared by the flush walk, not by reset.
  always_ff @(posedge clk) begin
    valid_q    <= valid_d;
    lk_tag_q   <= lk_tag_d;
    byp_tag_q  <= byp_tag_d;
    byp_data_q <= byp_data_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = hit_s;
  assign resp_data  = hit_s ? eff_data_s : {DATA_W{1'b0}};
  assign busy       = (state_q == FLUSH);

endmodule : cache_dm_array

// File: tb/tb_cache_dm_array.sv
// Directed self-checking bench for cache_dm_array at default parameters.
module tb_cache_dm_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [7:0]  lookup_addr;
  logic        resp_valid;
  logic        resp_hit;
  logic [18:0] resp_data;
  logic        fill_en;
  logic [7:0]  fill_addr;
  logic [18:0] fill_data;
  logic        flush_req;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  cache_dm_array dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_addr  (lookup_addr),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_data    (resp_data),
    .fill_en      (fill_en),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .flush_req    (flush_req),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    lookup_valid = 1'b0;
    lookup_addr  = 8'h00;
    fill_en      = 1'b0;
    fill_addr    = 8'h00;
    fill_data    = 19'h0;
    flush_req    = 1'b0;
  endtask

  // Count busy cycles starting from the current (already busy) cycle.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic lookup_check(input string tag, input logic [7:0] a,
                              input logic exp_hit, input logic [18:0] exp_data);
    lookup_valid = 1'b1;
    lookup_addr  = a;
    tick();
    lookup_valid = 1'b0;
    chk({tag, "_rv"},   {31'd0, resp_valid}, 32'd1);
    chk({tag, "_hit"},  {31'd0, resp_hit},   {31'd0, exp_hit});
    chk({tag, "_data"}, {13'd0, resp_data},  {13'd0, exp_data});
  endtask

  initial begin
    int n;
    logic any_rv;
    idle_inputs();
    rst = 1'b1;

    // 1. Reset then probe
    tick();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rv",   {31'd0, resp_valid}, 32'd0);
    chk("rst_hit",  {31'd0, resp_hit}, 32'd0);
    chk("rst_data", {13'd0, resp_data}, 32'd0);
    count_busy(n);
    chk("rst_busy_len", n, 32'd16);
    lookup_check("probe01", 8'h01, 1'b0, 19'h0);
    chk("probe_busy", {31'd0, busy}, 32'd0);

    // 2. Pipelined fills 0x01..0x04, lookups one cycle behind
    for (int i = 0; i <= 4; i++) begin
      fill_en      = (i < 4);
      fill_addr    = 8'(i + 1);
      fill_data    = 19'(i + 1);
      lookup_valid = (i > 0);
      lookup_addr  = 8'(i);
      tick();
      if (i > 0) begin
        chk("pipe_rv",   {31'd0, resp_valid}, 32'd1);
        chk("pipe_hit",  {31'd0, resp_hit}, 32'd1);
        chk("pipe_data", {13'd0, resp_data}, i);
      end else begin
        chk("pipe_rv0", {31'd0, resp_valid}, 32'd0);
      end
    end
    idle_inputs();
    tick();
    chk("pipe_idle_rv",   {31'd0, resp_valid}, 32'd0);
    chk("pipe_idle_data", {13'd0, resp_data}, 32'd0);

    // 3. Bypass: same tag hits with new data, new tag on same index misses
    fill_en = 1'b1; fill_addr = 8'h05; fill_data = 19'h5;
    lookup_check("byp_same", 8'h05, 1'b1, 19'h5);
    fill_en = 1'b1; fill_addr = 8'h15; fill_data = 19'h15;
    lookup_check("byp_diff", 8'h05, 1'b0, 19'h0);
    fill_en = 1'b0;
    lookup_check("byp_after", 8'h15, 1'b1, 19'h15);

    // 4. Conflict on index 1
    fill_en = 1'b1; fill_addr = 8'h01; fill_data = 19'h1;
    tick();
    fill_addr = 8'h21; fill_data = 19'h7FFFF;
    tick();
    fill_en = 1'b0;
    lookup_check("conf01", 8'h01, 1'b0, 19'h0);
    lookup_check("conf21", 8'h21, 1'b1, 19'h7FFFF);
    lookup_check("conf03", 8'h03, 1'b1, 19'h3);

    // 5. Flush; lookup in the flush_req cycle is still serviced
    flush_req = 1'b1;
    lookup_check("fl_req_lk", 8'h02, 1'b1, 19'h2);
    flush_req = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd1);
    n = 0;
    any_rv = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      lookup_valid = 1'b1; lookup_addr = 8'h03;
      fill_en = 1'b1; fill_addr = 8'h06; fill_data = 19'h66;
      flush_req = 1'b1;
      n++;
      tick();
      any_rv = any_rv | resp_valid;
    end
    idle_inputs();
    chk("fl_busy_len", n, 32'd16);
    chk("fl_drop_rv", {31'd0, any_rv}, 32'd0);
    lookup_check("fl01", 8'h21, 1'b0, 19'h0);
    lookup_check("fl02", 8'h02, 1'b0, 19'h0);
    lookup_check("fl03", 8'h03, 1'b0, 19'h0);
    lookup_check("fl04", 8'h04, 1'b0, 19'h0);
    lookup_check("fl06_dropfill", 8'h06, 1'b0, 19'h0);
    chk("fl_no_restart", {31'd0, busy}, 32'd0);

    // 6. Reset mid-flush restarts a full 16-cycle walk
    fill_en = 1'b1; fill_addr = 8'h07; fill_data = 19'h7;
    tick();
    fill_addr = 8'h0F; fill_data = 19'h0F;
    tick();
    fill_en = 1'b0;
    lookup_check("pre07", 8'h07, 1'b1, 19'h7);
    lookup_check("pre0f", 8'h0F, 1'b1, 19'hF);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(n);
    chk("mid_rst_busy_len", n, 32'd16);
    lookup_check("mid07", 8'h07, 1'b0, 19'h0);
    lookup_check("mid0f", 8'h0F, 1'b0, 19'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cache_dm_array

// File: doc/cache_dm_array.md
Name: cache_dm_array

Overview:
- Parametrised direct-mapped cache array: data store plus tag and valid storage, hit/miss lookup, fill port, and a sequential flush engine.
- Successor to the bare dual-port scratch array used in early cache bring-up.
- Adds tag compare, valid tracking, write-first bypass and whole-array invalidate.
- Sits between the core load/store path and the refill logic.

Parameters:
- ADDR_W, 8, full lookup/fill address width in bits.
- INDEX_W, 4, index bits taken from the low address bits. Number of lines is 2**INDEX_W. Must be < ADDR_W.
- DATA_W, 19, width of one cache line.
- TAG_W (localparam), ADDR_W-INDEX_W, tag taken from the high address bits.

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous active-high reset
- lookup_valid  in  1  lookup request this cycle
- lookup_addr  in  ADDR_W  lookup address
- resp_valid  out  1  response for the previous cycle's accepted lookup
- resp_hit  out  1  previous lookup hit (valid and tag match)
- resp_data  out  DATA_W  line data on hit, 0 on miss
- fill_en  in  1  write a line
- fill_addr  in  ADDR_W  fill address (index plus tag)
- fill_data  in  DATA_W  fill line data
- flush_req  in  1  request invalidation of all lines
- busy  out  1  flush in progress; lookups and fills are not accepted

Behaviour:
- State machine states: IDLE, FLUSH. A flush counter of INDEX_W bits tracks progress.
- Reset (rst=1 at a clock edge):
  - state goes to FLUSH and the counter goes to 0.
  - Outputs: busy=1, resp_valid=0, resp_hit=0, resp_data=0.
  - Data and tag contents are don't-care.
  - Reset asserted mid-flush restarts the flush from index 0.
- FLUSH:
  - Each cycle clears valid[counter], then increments the counter.
  - When the counter reaches 2**INDEX_W-1, that index is cleared and state goes to IDLE; the counter wraps to 0.
  - Exactly 2**INDEX_W cycles with busy=1.
  - flush_req is ignored; no restart.
  - Lookups are dropped: resp_valid=0 on the next cycle.
  - Fills are dropped: no write.
- IDLE:
  - busy=0.
  - flush_req=1 moves to FLUSH on the next edge.
  - Any lookup or fill in the same cycle as flush_req is still serviced.
- Lookup latency is 1 cycle. For an accepted lookup at edge N:
  - resp_valid=1 after edge N+1, with resp_hit and resp_data.
  - With no accepted lookup, resp_valid=0 and resp_hit=0; resp_data holds 0.
  - Back-to-back lookups are fully pipelined: one per cycle.
- Hit means valid[idx] and tag[idx]==lookup_addr[ADDR_W-1:INDEX_W].
- Fill:
  - At the edge, writes data[idx] and tag[idx] and sets valid[idx].
  - Overwrites any existing line (no eviction output).
- Same-cycle fill and lookup to the same index: write-first bypass.
  - The response is computed against the new tag and data.
  - Same tag gives a hit with fill_data. A different tag gives a miss.
- Fill and lookup to different indices proceed independently.
- No X on outputs after reset.

Decomposition:
- CORE_PKG gains:
  - cache_state_t enum (IDLE, FLUSH)
  - CACHE_ADDR_W=8, CACHE_INDEX_W=4, CACHE_DATA_W=19 defaults
- One natural sub-module: cache_sdp_ram, a parametrised simple dual-port RAM (1 write port, 1 registered read port), instantiated for {tag,data}.
- Valid bits and bypass comparison live in cache_dm_array, so flush can clear them.

Test Plan (default parameters):
1. Reset-then-probe:
   - Stimulus: rst=1 for 1 cycle, then 0.
   - Response: busy=1 for exactly 16 cycles, then 0. Lookup 0x01 gives resp_valid=1, resp_hit=0, resp_data=0 the next cycle.
2. Pipelined fill/lookup:
   - Stimulus: fills 0x01..0x04 with data 1..4 on consecutive cycles. Lookups 0x01..0x04 start one cycle later.
   - Response: consecutive responses hit=1, data 1,2,3,4, each 1 cycle after its lookup.
3. Bypass:
   - Stimulus: fill 0x05/data 5 and lookup 0x05 in the same cycle. Separately, fill 0x15 with lookup 0x05 in the same cycle.
   - Response: first gives hit=1, data 5. Second gives hit=0, data 0.
4. Conflict:
   - Stimulus: fill 0x01/data 1, then fill 0x21/data 0x7FFFF, then lookup 0x01 and 0x21.
   - Response: 0x01 misses. 0x21 hits with 0x7FFFF.
5. Flush:
   - Stimulus: flush_req with lines 1..4 valid.
   - Response: busy=1 for 16 cycles. A lookup during flush gives resp_valid=0. Fills during flush are dropped. Afterwards lookups 0x01..0x04 all miss.
6. Reset mid-flush:
   - Stimulus: rst asserted at flush cycle 5.
   - Response: busy stays 1 for a full 16 cycles from the reset edge; all lines invalid.
